// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if -- instruction memory request/response bus.
//
// One request may be outstanding. The requester drives imem_req/imem_addr and
// holds them until imem_gnt. The memory returns the word later with a
// single-cycle imem_rvalid pulse and imem_rdata.
//
//   imem_req    master -> slave   request valid
//   imem_addr   master -> slave   word-aligned request address
//   imem_gnt    slave  -> master  request accepted this cycle
//   imem_rvalid slave  -> master  read data valid
//   imem_rdata  slave  -> master  instruction word
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- single-outstanding instruction fetch unit.
//
// A two-state FSM (REQ / WAIT) issues one memory request at a time. Returned
// words go to a registered output (inst/inst_pc) with a one-entry skid buffer
// behind it, so a response always has somewhere to land while decode stalls.
// A redirect retargets the PC, flushes both entries and discards any response
// that belongs to the old instruction stream.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active low
//   redirect_en  PC redirect from the jump/branch stage
//   redirect_pc  redirect target (low two bits ignored)
//   stall        decode not ready to accept inst
//   imem         instruction memory bus (master side)
//   inst_valid   inst / inst_pc hold a valid instruction
//   inst         fetched instruction word
//   inst_pc      address of inst
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  input  logic                 stall,
  instr_fetch_if.master        imem,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [31:0]          inst_pc
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;        // address of the outstanding request
  logic        squash;        // outstanding response belongs to a stale stream
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  logic        req_c;         // request presented this cycle
  logic        accept;        // request granted this cycle
  logic        resp;          // response arriving while one is expected
  logic        deliver;       // response is kept (not squashed / redirected)
  logic        consume;       // decode takes the output register this cycle

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    accept     = 1'b0;
    resp       = 1'b0;
    case (state)
      ST_REQ: begin
        // Withhold the request while the skid is full so that the response
        // is guaranteed a slot; also quiet during reset. imem_rvalid is
        // deliberately not looked at here.
        req_c  = i_rst && !skid_valid;
        accept = req_c && imem.imem_gnt;
        if (accept) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        resp = imem.imem_rvalid;
        if (resp) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc;

  assign deliver = resp && !squash && !redirect_en;
  assign consume = inst_valid && !stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_REQ;
    else        state <= state_next;
  end

  // NOTE: the instruction/skid data registers are reset as well, because the
  // outputs must read zero during reset and the skid feeds inst directly.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc         <= RESET_PC;
      req_pc     <= 32'h0;
      squash     <= 1'b0;
      skid_valid <= 1'b0;
      skid_inst  <= 32'h0;
      skid_pc    <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
    end else begin
      // Redirect wins over sequential advance; pc+4 wraps silently.
      if (redirect_en)  pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)  pc <= pc + 32'd4;

      if (accept) req_pc <= pc;

      // A redirect coincident with the response already drops that response,
      // so squash is only armed when a response is still to come.
      if (resp) squash <= 1'b0;
      if (redirect_en && (accept || (state == ST_WAIT && !resp))) squash <= 1'b1;

      if (redirect_en) begin
        inst_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!inst_valid || consume) begin
        // Output register free next cycle: refill from skid first (older),
        // then from the arriving response.
        if (skid_valid) begin
          inst       <= skid_inst;
          inst_pc    <= skid_pc;
          inst_valid <= 1'b1;
          skid_valid <= deliver;
          if (deliver) begin
            skid_inst <= imem.imem_rdata;
            skid_pc   <= req_pc;
          end
        end else if (deliver) begin
          inst       <= imem.imem_rdata;
          inst_pc    <= req_pc;
          inst_valid <= 1'b1;
        end else begin
          inst_valid <= 1'b0;
        end
      end else if (deliver) begin
        // Output held by stall: park the response in the skid.
        skid_valid <= 1'b1;
        skid_inst  <= imem.imem_rdata;
        skid_pc    <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- directed self-checking bench for instr_fetch.
//
// A small zero-wait memory model (gnt held high, rvalid one cycle after the
// grant, rdata = addr ^ KEY) can be enabled; otherwise the memory signals are
// driven by hand. Inputs change 1 time unit after the rising edge; outputs are
// checked there too, well away from the edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        i_clk;
  logic        i_rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;
  bit auto_mem = 1'b0;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem        (imem_bus),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; when the memory model is on, answer a grant seen in
  // the previous cycle with rvalid in the next one.
  task automatic step();
    logic        fire;
    logic [31:0] addr;
    @(negedge i_clk);
    fire = imem_bus.imem_req && imem_bus.imem_gnt;
    addr = imem_bus.imem_addr;
    @(posedge i_clk);
    #1;
    if (auto_mem) begin
      imem_bus.imem_rvalid = fire;
      imem_bus.imem_rdata  = fire ? (addr ^ KEY) : 32'h0;
    end
  endtask

  initial begin
    i_rst                = 1'b0;
    redirect_en          = 1'b0;
    redirect_pc          = 32'h0;
    stall                = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;

    // ---- reset state ----
    step(); step();
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_req", imem_bus.imem_req, 1'b0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);

    // ---- zero-wait streaming: 0, 4, 8 every 2 cycles ----
    i_rst = 1'b1; imem_bus.imem_gnt = 1'b1; auto_mem = 1'b1;
    #1;
    check("rel_req", imem_bus.imem_req, 1'b1);
    check("rel_addr", imem_bus.imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stream_gap", inst_valid, 1'b0);
      step();
      check("stream_valid", inst_valid, 1'b1);
      check("stream_pc", inst_pc, 32'(4 * k));
      check("stream_inst", inst, 32'(4 * k) ^ KEY);
    end

    // ---- mid-stream reset ----
    i_rst = 1'b0;
    #1;
    check("rst2_valid", inst_valid, 1'b0);
    check("rst2_inst", inst, 32'h0);
    check("rst2_req", imem_bus.imem_req, 1'b0);
    check("rst2_addr", imem_bus.imem_addr, 32'h0);
    step(); step();

    // ---- stall for 6 cycles from the first delivery ----
    i_rst = 1'b1;
    step(); step();
    check("stl_first_pc", inst_pc, 32'h0);
    check("stl_first_v", inst_valid, 1'b1);
    stall = 1'b1;
    step(); step(); step();
    check("stl_hold_v", inst_valid, 1'b1);
    check("stl_hold_pc", inst_pc, 32'h0);
    check("stl_req_low", imem_bus.imem_req, 1'b0);
    step(); step(); step();
    check("stl_hold_pc2", inst_pc, 32'h0);
    check("stl_hold_inst2", inst, KEY);
    check("stl_req_low2", imem_bus.imem_req, 1'b0);
    stall = 1'b0;
    step();
    check("stl_skid_v", inst_valid, 1'b1);
    check("stl_skid_pc", inst_pc, 32'h4);
    check("stl_skid_inst", inst, 32'h4 ^ KEY);
    check("stl_after_req", imem_bus.imem_req, 1'b1);
    check("stl_after_addr", imem_bus.imem_addr, 32'h8);
    step();
    check("stl_gap", inst_valid, 1'b0);

    // ---- redirect to 0x100 while waiting for 0x8 ----
    redirect_en = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    check("rd1_valid", inst_valid, 1'b0);
    check("rd1_req", imem_bus.imem_req, 1'b1);
    check("rd1_addr", imem_bus.imem_addr, 32'h100);
    step();
    check("rd1_gap", inst_valid, 1'b0);
    step();
    check("rd1_v", inst_valid, 1'b1);
    check("rd1_pc", inst_pc, 32'h100);
    check("rd1_inst", inst, 32'h100 ^ KEY);

    // ---- unaligned redirect 0x203 coincident with a grant ----
    redirect_en = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_en = 1'b0;
    check("rd2_flush", inst_valid, 1'b0);
    check("rd2_wait_req", imem_bus.imem_req, 1'b0);
    step();
    check("rd2_squash_v", inst_valid, 1'b0);
    check("rd2_addr", imem_bus.imem_addr, 32'h200);
    check("rd2_req", imem_bus.imem_req, 1'b1);
    step(); step();
    check("rd2_pc0", inst_pc, 32'h200);
    check("rd2_inst0", inst, 32'h200 ^ KEY);
    check("rd2_v0", inst_valid, 1'b1);
    step(); step();
    check("rd2_pc1", inst_pc, 32'h204);
    check("rd2_v1", inst_valid, 1'b1);

    // ---- redirect with stall, skid full and rvalid in one cycle ----
    stall = 1'b1;
    step(); step();
    check("rd3_pre_pc", inst_pc, 32'h204);
    check("rd3_pre_req", imem_bus.imem_req, 1'b0);
    auto_mem = 1'b0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    redirect_en = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_en = 1'b0; imem_bus.imem_rvalid = 1'b0;
    check("rd3_flush", inst_valid, 1'b0);
    check("rd3_req", imem_bus.imem_req, 1'b1);
    check("rd3_addr", imem_bus.imem_addr, 32'h40);
    stall = 1'b0; imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    check("rd3_wait_req", imem_bus.imem_req, 1'b0);
    step();
    check("rd3_wait_v", inst_valid, 1'b0);
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h40 ^ KEY;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("rd3_v", inst_valid, 1'b1);
    check("rd3_pc", inst_pc, 32'h40);
    check("rd3_inst", inst, 32'h40 ^ KEY);

    // ---- ungranted request: stable, then retargeted ----
    stall = 1'b1;
    check("ng_addr0", imem_bus.imem_addr, 32'h44);
    step();
    check("ng_req", imem_bus.imem_req, 1'b1);
    check("ng_addr1", imem_bus.imem_addr, 32'h44);
    check("ng_hold_pc", inst_pc, 32'h40);
    redirect_en = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_en = 1'b0;
    check("ng_retarget", imem_bus.imem_addr, 32'h80);
    check("ng_flush", inst_valid, 1'b0);

    // ---- redirect in WAIT before the response: squash it ----
    stall = 1'b0; imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'hC0;
    step();
    redirect_en = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1111_1111;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("sq_drop_v", inst_valid, 1'b0);
    check("sq_req", imem_bus.imem_req, 1'b1);
    check("sq_addr", imem_bus.imem_addr, 32'hC0);
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h2222_2222;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("sq_v", inst_valid, 1'b1);
    check("sq_pc", inst_pc, 32'hC0);
    check("sq_inst", inst, 32'h2222_2222);

    // ---- reset during WAIT, late rvalid after release ----
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    i_rst = 1'b0;
    #1;
    check("rw_valid", inst_valid, 1'b0);
    check("rw_inst", inst, 32'h0);
    check("rw_req", imem_bus.imem_req, 1'b0);
    step();
    i_rst = 1'b1;
    #1;
    check("rw_rel_req", imem_bus.imem_req, 1'b1);
    check("rw_rel_addr", imem_bus.imem_addr, 32'h0);
    step();
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h3333_3333;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("rw_ign_v", inst_valid, 1'b0);
    check("rw_ign_req", imem_bus.imem_req, 1'b1);
    check("rw_ign_addr", imem_bus.imem_addr, 32'h0);
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    check("rw_wait_v", inst_valid, 1'b0);
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = KEY;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("rw_v", inst_valid, 1'b1);
    check("rw_pc", inst_pc, 32'h0);
    check("rw_inst", inst, KEY);

    // ---- pc wrap-around at the top of the address space ----
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_en = 1'b0;
    check("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    check("wr_next", imem_bus.imem_addr, 32'h0);
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h4444_4444;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("wr_v", inst_valid, 1'b1);
    check("wr_pc", inst_pc, 32'hFFFF_FFFC);
    check("wr_inst", inst, 32'h4444_4444);
    check("wr_req_addr", imem_bus.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
